// File: rtl/ir_pkg.sv
// Shared definitions for the IR command scheduler: bus offsets, status/control bits, FSM states.
package ir_pkg;

  localparam logic [7:0] OffsWord = 8'd0;
  localparam logic [7:0] OffsDur  = 8'd1;
  localparam logic [7:0] OffsCtrl = 8'd2;

  localparam int unsigned CtrlFlushBit  = 0;
  localparam int unsigned CtrlOvfClrBit = 1;

  localparam logic [3:0] StopCmd = 4'h0;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StStop
  } ir_state_e;

endpackage

// File: rtl/ir_cmd_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra wrap bit to tell full from empty.
module ir_cmd_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [WIDTH-1:0] mem_q [Depth];
  logic [AW:0]      wr_q, rd_q;
  logic             push_ok, pop_ok;

  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == (AW + 1)'(Depth));
  assign empty_o = (wr_q == rd_q);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // A pop frees a slot in the same cycle, so a push while full is accepted alongside it.
  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign push_ok = push_i && !flush_i && (!full_o || pop_ok);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ir_cmd_scheduler.sv
// Bus-mapped sequencer replaying queued IR words for N packet periods, then a stop command.
// Optional interrupt output when the queue drains: define IR_SCHED_IRQ_EN.
module ir_cmd_scheduler
  import ir_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR  = 8'h91,
  parameter int unsigned FIFO_AW    = 2,
  parameter logic [7:0]  RESET_WORD = 8'h01
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic       SEND_PACKET,
  output logic [7:0] IR_CMD,
  output logic       IR_CMD_WE,
  output logic       BUSY
`ifdef IR_SCHED_IRQ_EN
  ,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
`endif
);

  logic wr_word, wr_push, wr_ctrl, rd_stat, flush, pop;
  logic [7:0] stage_q, cur_word_q, cur_dur_q, rem_q, ir_cmd_q, status_q;
  logic ovf_q, ir_we_q;
  ir_state_e state_q;

  logic [15:0]      fifo_din, fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_count;

  assign wr_word = BUS_WE && (BUS_ADDR == BASE_ADDR + OffsWord);
  assign wr_push = BUS_WE && (BUS_ADDR == BASE_ADDR + OffsDur);
  assign wr_ctrl = BUS_WE && (BUS_ADDR == BASE_ADDR + OffsCtrl);
  assign rd_stat = !BUS_WE && (BUS_ADDR == BASE_ADDR + OffsCtrl);
  assign flush   = wr_ctrl && BUS_DATA[CtrlFlushBit];

  assign fifo_din = {stage_q, (BUS_DATA == 8'd0) ? 8'd1 : BUS_DATA};
  assign pop = !flush && !fifo_empty &&
               ((state_q == StIdle) ||
                ((state_q == StRun) && SEND_PACKET && (rem_q == 8'd1)));

  assign BUS_DATA  = rd_stat ? status_q : 8'bz;
  assign IR_CMD    = ir_cmd_q;
  assign IR_CMD_WE = ir_we_q;
  assign BUSY      = (state_q != StIdle);

  ir_cmd_fifo #(
    .WIDTH(16),
    .AW   (FIFO_AW)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .push_i (wr_push),
    .pop_i  (pop),
    .flush_i(flush),
    .din_i  (fifo_din),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stage_q  <= RESET_WORD;
      ovf_q    <= 1'b0;
      status_q <= 8'h20;
    end else begin
      if (wr_word) stage_q <= BUS_DATA;
      if (wr_push && !flush && fifo_full && !pop) begin
        ovf_q <= 1'b1;
      end else if (wr_ctrl && BUS_DATA[CtrlOvfClrBit]) begin
        ovf_q <= 1'b0;
      end
      status_q <= {BUSY, fifo_full, fifo_empty, ovf_q, 1'b0, 3'(fifo_count)};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      cur_word_q <= RESET_WORD;
      cur_dur_q  <= 8'd1;
      rem_q      <= 8'd0;
      ir_cmd_q   <= RESET_WORD;
      ir_we_q    <= 1'b0;
    end else begin
      ir_we_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pop) begin
            cur_word_q <= fifo_dout[15:8];
            cur_dur_q  <= fifo_dout[7:0];
            state_q    <= StLoad;
          end
        end
        // A flush here skips the load strobe so two strobes are never adjacent.
        StLoad: begin
          if (flush) begin
            state_q <= StStop;
          end else begin
            ir_cmd_q <= cur_word_q;
            ir_we_q  <= 1'b1;
            rem_q    <= cur_dur_q;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (flush) begin
            state_q <= StStop;
          end else if (SEND_PACKET) begin
            rem_q <= rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              if (pop) begin
                cur_word_q <= fifo_dout[15:8];
                cur_dur_q  <= fifo_dout[7:0];
                state_q    <= StLoad;
              end else begin
                state_q <= StStop;
              end
            end
          end
        end
        StStop: begin
          ir_cmd_q <= {StopCmd, cur_word_q[3:0]};
          ir_we_q  <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef IR_SCHED_IRQ_EN
  logic enter_stop, raise_q;

  assign enter_stop = ((state_q == StLoad) && flush) ||
                      ((state_q == StRun) &&
                       (flush || (SEND_PACKET && (rem_q == 8'd1) && !pop)));
  assign BUS_INTERRUPT_RAISE = raise_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      raise_q <= 1'b0;
    end else if (enter_stop) begin
      raise_q <= 1'b1;
    end else if (BUS_INTERRUPT_ACK) begin
      raise_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Directed bench for ir_cmd_scheduler; strobes are logged and compared against hand-built lists.
module tb_ir_cmd_scheduler;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] BUS_ADDR = 8'h00;
  logic       BUS_WE = 1'b0;
  logic       SEND_PACKET = 1'b0;
  logic [7:0] IR_CMD;
  logic       IR_CMD_WE;
  logic       BUSY;
  wire  [7:0] BUS_DATA;
  logic [7:0] bus_drv = 8'h00;
  logic       bus_oe = 1'b0;
`ifdef IR_SCHED_IRQ_EN
  logic       irq_raise;
  logic       irq_ack = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];
  logic       we_prev = 1'b0;
  logic [7:0] stat;

  assign BUS_DATA = bus_oe ? bus_drv : 8'bz;

  always #5 CLK = ~CLK;

  ir_cmd_scheduler dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .BUS_DATA   (BUS_DATA),
    .BUS_ADDR   (BUS_ADDR),
    .BUS_WE     (BUS_WE),
    .SEND_PACKET(SEND_PACKET),
    .IR_CMD     (IR_CMD),
    .IR_CMD_WE  (IR_CMD_WE),
    .BUSY       (BUSY)
`ifdef IR_SCHED_IRQ_EN
    ,
    .BUS_INTERRUPT_RAISE(irq_raise),
    .BUS_INTERRUPT_ACK  (irq_ack)
`endif
  );

  // Log every strobe and flag back-to-back strobes.
  always @(negedge CLK) begin
    if (!RESET) begin
      assert (!(IR_CMD_WE && we_prev)) else begin
        fails++;
        $error("FAIL consec_we: observed two strobes in a row, expected a gap");
      end
      if (IR_CMD_WE) log_q.push_back(IR_CMD);
    end
    we_prev = IR_CMD_WE;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check($sformatf("%s_%0d", tag, i), {24'h0, log_q[i]}, {24'h0, exp_q[i]});
    end
    log_q.delete();
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    BUS_ADDR = addr;
    BUS_WE   = 1'b1;
    bus_drv  = data;
    bus_oe   = 1'b1;
    step();
    BUS_WE   = 1'b0;
    bus_oe   = 1'b0;
    BUS_ADDR = 8'h00;
  endtask

  task automatic read_status(output logic [7:0] v);
    BUS_ADDR = 8'h93;
    BUS_WE   = 1'b0;
    #1;
    v = BUS_DATA;
    BUS_ADDR = 8'h00;
  endtask

  task automatic pulse();
    SEND_PACKET = 1'b1;
    step();
    SEND_PACKET = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      wait_cycles(3);
      pulse();
    end
  endtask

  initial begin
    wait_cycles(2);
    RESET = 1'b0;
    step();
    check("rst_ir_cmd", {24'h0, IR_CMD}, 32'h01);
    check("rst_we", {31'h0, IR_CMD_WE}, 32'h0);
    check("rst_busy", {31'h0, BUSY}, 32'h0);
    read_status(stat);
    check("rst_status", {24'h0, stat}, 32'h20);

    // Single entry: exact latency of the load and stop strobes.
    bus_write(8'h91, 8'h51);
    bus_write(8'h92, 8'h03);
    step();
    check("t1_we_early", {31'h0, IR_CMD_WE}, 32'h0);
    step();
    check("t1_load_we", {31'h0, IR_CMD_WE}, 32'h1);
    check("t1_load_cmd", {24'h0, IR_CMD}, 32'h51);
    ticks(3);
    check("t1_busy_stop", {31'h0, BUSY}, 32'h1);
    step();
    check("t1_stop_we", {31'h0, IR_CMD_WE}, 32'h1);
    check("t1_stop_cmd", {24'h0, IR_CMD}, 32'h01);
    check("t1_busy_done", {31'h0, BUSY}, 32'h0);
    step();
    exp_q = {8'h51, 8'h01};
    check_log("t1_log");

    // Back-to-back entries with no stop in between.
    bus_write(8'h91, 8'h52);
    bus_write(8'h92, 8'h01);
    bus_write(8'h91, 8'h92);
    bus_write(8'h92, 8'h02);
    ticks(3);
    wait_cycles(3);
    exp_q = {8'h52, 8'h92, 8'h02};
    check_log("t2_log");

    // Overflow: 6th push is dropped while 4 wait behind the running entry.
    for (int i = 1; i <= 6; i++) begin
      bus_write(8'h91, 8'((i << 4) | 1));
      bus_write(8'h92, 8'h01);
    end
    step();
    read_status(stat);
    check("t3_status_ovf", {24'h0, stat}, 32'hD4);
    bus_write(8'h93, 8'h02);
    step();
    read_status(stat);
    check("t3_status_clr", {24'h0, stat}, 32'hC4);
    ticks(5);
    wait_cycles(3);
    exp_q = {8'h11, 8'h21, 8'h31, 8'h41, 8'h51, 8'h01};
    check_log("t3_log");

    // Flush mid-run with one entry still queued.
    bus_write(8'h91, 8'h73);
    bus_write(8'h92, 8'h05);
    bus_write(8'h91, 8'h83);
    bus_write(8'h92, 8'h01);
    ticks(3);
    wait_cycles(2);
    bus_write(8'h93, 8'h01);
    check("t4_flush_we0", {31'h0, IR_CMD_WE}, 32'h0);
    step();
    check("t4_stop_we", {31'h0, IR_CMD_WE}, 32'h1);
    check("t4_stop_cmd", {24'h0, IR_CMD}, 32'h03);
    check("t4_busy", {31'h0, BUSY}, 32'h0);
    step();
    read_status(stat);
    check("t4_status", {24'h0, stat}, 32'h20);
    wait_cycles(4);
    exp_q = {8'h73, 8'h03};
    check_log("t4_log");

    // Duration 0 behaves as 1.
    bus_write(8'h91, 8'h35);
    bus_write(8'h92, 8'h00);
    wait_cycles(4);
    check("t5_no_early_stop", log_q.size(), 32'd1);
    ticks(1);
    wait_cycles(3);
    exp_q = {8'h35, 8'h05};
    check_log("t5_dur0_log");

    // Reset mid-run: no stop strobe, stage back to reset word.
    bus_write(8'h91, 8'h46);
    bus_write(8'h92, 8'h03);
    ticks(1);
    RESET = 1'b1;
    #1;
    check("t5_rst_cmd", {24'h0, IR_CMD}, 32'h01);
    check("t5_rst_we", {31'h0, IR_CMD_WE}, 32'h0);
    check("t5_rst_busy", {31'h0, BUSY}, 32'h0);
    wait_cycles(2);
    RESET = 1'b0;
    wait_cycles(4);
    read_status(stat);
    check("t5_rst_status", {24'h0, stat}, 32'h20);
    bus_write(8'h92, 8'h01);
    ticks(1);
    wait_cycles(3);
    exp_q = {8'h46, 8'h01, 8'h01};
    check_log("t5_rst_log");

`ifdef IR_SCHED_IRQ_EN
    check("t6_irq_idle", {31'h0, irq_raise}, 32'h0);
    bus_write(8'h91, 8'h57);
    bus_write(8'h92, 8'h01);
    ticks(1);
    check("t6_irq_set", {31'h0, irq_raise}, 32'h1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("t6_irq_ack", {31'h0, irq_raise}, 32'h0);
    bus_write(8'h92, 8'h01);
    ticks(1);
    wait_cycles(2);
    check("t6_irq_again", {31'h0, irq_raise}, 32'h1);
    log_q.delete();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
